i2c_transaction_master: RTL

Parametrised I2C master for the lab I2C/TMP101 design. It generalises the single-address-byte phase-1 sender into a full transaction engine: START, 7-bit address plus R/W, 0–15 data bytes in either direction with per-byte ACK handling, then STOP. It sits between a system control FSM (Go/Busy/Done, byte handshakes) and the SDA/SCL pins.

---
 rtl/i2c_transaction_master.sv | 291 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_transaction_master.sv
// I2C master transaction engine: START, 7-bit address + R/W, 0..2^CountWidth-1
// data bytes in either direction with per-byte ACK handling, then STOP.
//
// Ports:
//   clock, Reset          system clock, async active-high reset
//   Go                    level, accepted only in IDLE; starts a transaction
//   SlaveAddress          7-bit target address, latched with Go
//   ReadNotWrite          1 = read, 0 = write, latched with Go
//   ByteCount             data byte count (0 = address-only probe), latched with Go
//   WriteData             next byte to transmit
//   WriteDataReq          one-clock request for the next WriteData
//   ReadData / ReadValid  last received byte and its one-clock strobe
//   Busy / Done           transaction in progress / one-clock end pulse
//   AckError              slave NACK seen; cleared when the next Go is accepted
//   SCL                   push-pull bus clock
//   SDA                   open-drain bus data (drives 0 or z only)
module i2c_transaction_master #(
    parameter int ClockFrequency = 60000000,
    parameter int BaudRate       = 30000,
    parameter int CountWidth     = 4
) (
    input  logic                  clock,
    input  logic                  Reset,
    input  logic                  Go,
    input  logic [6:0]            SlaveAddress,
    input  logic                  ReadNotWrite,
    input  logic [CountWidth-1:0] ByteCount,
    input  logic [7:0]            WriteData,
    output logic                  WriteDataReq,
    output logic [7:0]            ReadData,
    output logic                  ReadValid,
    output logic                  Busy,
    output logic                  Done,
    output logic                  AckError,
    output logic                  SCL,
    inout  wire                   SDA
);

    localparam int QDIV = ClockFrequency / (4 * BaudRate);
    localparam int QW   = (QDIV > 1) ? $clog2(QDIV) : 1;
    localparam logic [QW-1:0] QMAX = QW'(QDIV - 1);
    localparam logic [CountWidth-1:0] CNT_ONE  = CountWidth'(1);
    localparam logic [CountWidth-1:0] CNT_ZERO = '0;

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WRITE,
        S_WRITE_ACK, S_READ, S_READ_ACK, S_STOP, S_DONE
    } state_t;

    state_t                state, state_n;
    logic [QW-1:0]         qcnt, qcnt_n;
    logic [1:0]            q, q_n;
    logic [2:0]            bitcnt, bitcnt_n;
    logic [7:0]            shreg, shreg_n;
    logic [CountWidth-1:0] remaining, remaining_n;
    logic                  rnw, rnw_n;
    logic                  nack, nack_n;
    logic                  scl_q, scl_n;
    logic                  sda_low, sda_low_n;
    logic                  busy_n, done_n, ack_error_n;
    logic [7:0]            read_data_n;
    logic                  read_valid_n, wdr_n;
    logic                  tick;
    logic                  sda_in;

    assign SDA    = sda_low ? 1'b0 : 1'bz;
    assign sda_in = SDA;
    assign SCL    = scl_q;
    assign tick   = Busy && (qcnt == QMAX);

    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            state        <= S_IDLE;
            qcnt         <= '0;
            q            <= '0;
            bitcnt       <= '0;
            shreg        <= '0;
            remaining    <= '0;
            rnw          <= 1'b0;
            nack         <= 1'b0;
            scl_q        <= 1'b1;
            sda_low      <= 1'b0;
            Busy         <= 1'b0;
            Done         <= 1'b0;
            AckError     <= 1'b0;
            ReadData     <= 8'h00;
            ReadValid    <= 1'b0;
            WriteDataReq <= 1'b0;
        end else begin
            state        <= state_n;
            qcnt         <= qcnt_n;
            q            <= q_n;
            bitcnt       <= bitcnt_n;
            shreg        <= shreg_n;
            remaining    <= remaining_n;
            rnw          <= rnw_n;
            nack         <= nack_n;
            scl_q        <= scl_n;
            sda_low      <= sda_low_n;
            Busy         <= busy_n;
            Done         <= done_n;
            AckError     <= ack_error_n;
            ReadData     <= read_data_n;
            ReadValid    <= read_valid_n;
            WriteDataReq <= wdr_n;
        end
    end

    always_comb begin
        state_n      = state;
        qcnt_n       = qcnt;
        q_n          = q;
        bitcnt_n     = bitcnt;
        shreg_n      = shreg;
        remaining_n  = remaining;
        rnw_n        = rnw;
        nack_n       = nack;
        scl_n        = scl_q;
        sda_low_n    = sda_low;
        busy_n       = Busy;
        done_n       = 1'b0;
        ack_error_n  = AckError;
        read_data_n  = ReadData;
        read_valid_n = 1'b0;
        wdr_n        = 1'b0;

        if (Busy) begin
            qcnt_n = tick ? '0 : qcnt + QW'(1);
        end

        unique case (state)
            S_IDLE: begin
                scl_n     = 1'b1;
                sda_low_n = 1'b0;
                if (Go) begin
                    shreg_n     = {SlaveAddress, ReadNotWrite};
                    rnw_n       = ReadNotWrite;
                    remaining_n = ByteCount;
                    ack_error_n = 1'b0;
                    busy_n      = 1'b1;
                    qcnt_n      = '0;
                    q_n         = '0;
                    state_n     = S_START;
                end
            end

            S_START: begin
                if (tick) begin
                    if (q == 2'd0) begin
                        sda_low_n = 1'b1;
                        q_n       = 2'd1;
                    end else begin
                        scl_n    = 1'b0;
                        q_n      = 2'd0;
                        bitcnt_n = 3'd7;
                        state_n  = S_ADDR;
                    end
                end
            end

            S_ADDR, S_WRITE: begin
                if (tick) begin
                    q_n = q + 2'd1;
                    unique case (q)
                        2'd0: sda_low_n = ~shreg[7];
                        2'd1: scl_n = 1'b1;
                        2'd2: begin end
                        2'd3: begin
                            scl_n    = 1'b0;
                            shreg_n  = {shreg[6:0], 1'b0};
                            bitcnt_n = bitcnt - 3'd1;
                            if (bitcnt == 3'd0) begin
                                state_n = (state == S_ADDR) ? S_ADDR_ACK
                                                            : S_WRITE_ACK;
                            end
                        end
                    endcase
                end
            end

            S_ADDR_ACK, S_WRITE_ACK: begin
                if (tick) begin
                    q_n = q + 2'd1;
                    unique case (q)
                        2'd0: begin
                            sda_low_n = 1'b0;
                            // Ask for the next byte a full slot before it is loaded.
                            if (state == S_ADDR_ACK)
                                wdr_n = !rnw && (remaining != CNT_ZERO);
                            else
                                wdr_n = (remaining != CNT_ONE);
                        end
                        2'd1: scl_n = 1'b1;
                        2'd2: nack_n = sda_in;
                        2'd3: begin
                            scl_n    = 1'b0;
                            bitcnt_n = 3'd7;
                            if (nack) begin
                                ack_error_n = 1'b1;
                                state_n     = S_STOP;
                            end else if (state == S_ADDR_ACK) begin
                                if (remaining == CNT_ZERO) begin
                                    state_n = S_STOP;
                                end else if (rnw) begin
                                    state_n = S_READ;
                                end else begin
                                    shreg_n = WriteData;
                                    state_n = S_WRITE;
                                end
                            end else begin
                                remaining_n = remaining - CNT_ONE;
                                if (remaining == CNT_ONE) begin
                                    state_n = S_STOP;
                                end else begin
                                    shreg_n = WriteData;
                                    state_n = S_WRITE;
                                end
                            end
                        end
                    endcase
                end
            end

            S_READ: begin
                if (tick) begin
                    q_n = q + 2'd1;
                    unique case (q)
                        2'd0: sda_low_n = 1'b0;
                        2'd1: scl_n = 1'b1;
                        2'd2: shreg_n = {shreg[6:0], sda_in};
                        2'd3: begin
                            scl_n    = 1'b0;
                            bitcnt_n = bitcnt - 3'd1;
                            if (bitcnt == 3'd0) begin
                                read_data_n  = shreg;
                                read_valid_n = 1'b1;
                                state_n      = S_READ_ACK;
                            end
                        end
                    endcase
                end
            end

            S_READ_ACK: begin
                if (tick) begin
                    q_n = q + 2'd1;
                    unique case (q)
                        // ACK while bytes remain, NACK the last one.
                        2'd0: sda_low_n = (remaining != CNT_ONE);
                        2'd1: scl_n = 1'b1;
                        2'd2: begin end
                        2'd3: begin
                            scl_n       = 1'b0;
                            bitcnt_n    = 3'd7;
                            remaining_n = remaining - CNT_ONE;
                            state_n     = (remaining == CNT_ONE) ? S_STOP
                                                                 : S_READ;
                        end
                    endcase
                end
            end

            S_STOP: begin
                if (tick) begin
                    q_n = q + 2'd1;
                    if (q == 2'd0) begin
                        scl_n     = 1'b0;
                        sda_low_n = 1'b1;
                    end else if (q == 2'd1) begin
                        scl_n = 1'b1;
                    end else begin
                        sda_low_n = 1'b0;
                        q_n       = 2'd0;
                        state_n   = S_DONE;
                    end
                end
            end

            S_DONE: begin
                done_n  = 1'b1;
                busy_n  = 1'b0;
                qcnt_n  = '0;
                q_n     = 2'd0;
                state_n = S_IDLE;
            end

            default: state_n = S_IDLE;
        endcase
    end

endmodule
